exp_pulse_gen: RTL and testbench
================================

# exp_pulse_gen

- Synthetic detector-pulse source for the shaping-filter chain.
- On each accepted trigger it produces an ADC-like sample stream: a linear rise to a programmed amplitude, then an exponential decay, on top of a constant baseline.
- The decay is modelled as x(n) = x(n-1) − x(n-1)·2^−DECAY_SHIFT.
- It drives the filter input in place of the real ADC, for bring-up and closed-loop verification of the deconvolution/trapezoid path.

## Interface
- DATA_W, 12: output sample width; equals the ADC data width consumed by the filter.
- FRAC, 8: fractional bits of the internal accumulator.
- ACC_W, 21: accumulator width; must be ≥ DATA_W+FRAC+1.
- RISE_LOG2, 2: rise length is 2^RISE_LOG2 cycles.
- DECAY_SHIFT, 4: decay factor exponent.
- BASELINE, 100: constant pedestal added to every output sample.
- TAIL_LEN, 1024: maximum number of decay cycles before forced return to idle.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- trig_valid  in  1  trigger request.
- trig_amp  in  DATA_W  pulse amplitude (integer ADC counts); sampled on acceptance.
- trig_ready  out  1  generator can accept a trigger (combinational from state).
- adc_data  out  DATA_W  registered sample stream.
- pulse_active  out  1  high while state ≠ IDLE (registered).
- pulse_cnt  out  16  accepted-trigger count; wraps 0xFFFF→0.

## Operation
- acc is an unsigned fixed-point accumulator of ACC_W bits with FRAC fractional bits.
- A trigger is accepted on an edge where trig_valid && trig_ready.
- FSM states: IDLE, RISE, DECAY.
- IDLE:
  - acc=0; trig_ready=1.
  - On accept: latch step=(trig_amp<<FRAC)>>RISE_LOG2, rise_cnt←0, state←RISE, pulse_cnt+1.
- RISE:
  - Each edge: acc+=step, rise_cnt+1.
  - After 2^RISE_LOG2 edges: state←DECAY, tail_cnt←0. acc then holds exactly (amp<<FRAC) minus truncation of step.
- DECAY:
  - Each edge: acc_next=acc−(acc>>DECAY_SHIFT), tail_cnt+1.
  - If acc_next[ACC_W-1:FRAC]==0 or tail_cnt==TAIL_LEN−1: acc←0, state←IDLE. Otherwise acc←acc_next.
- Output: adc_data ← min(BASELINE + acc[ACC_W-1:FRAC], 2^DATA_W−1), registered every cycle.
- All accumulator additions saturate at 2^ACC_W−1; they never wrap.
- Reset (async, any state): state=IDLE, acc=0, adc_data=BASELINE, pulse_active=0, pulse_cnt=0. trig_ready=1 once reset is released.
- trig_amp=0 is accepted as a normal pulse: the rise has zero step and the pulse exits on the first DECAY edge.

## Timing
- Accept edge E0: state becomes RISE; acc is unchanged at E0.
- acc reaches its peak at edge E0+2^RISE_LOG2. adc_data shows the peak one edge later, at E0+2^RISE_LOG2+1.
- adc_data always lags acc by exactly 1 cycle.
- pulse_active rises at E0+1 and falls one edge after state returns to IDLE.
- trig_ready is low in RISE. In DECAY it is low unless the pile-up feature is enabled.
- A trigger that is not accepted is dropped; there is no queueing and pulse_cnt is unchanged.

## Configuration
- PULSE_GEN_PILEUP_EN defined:
  - trig_ready=1 in DECAY as well as IDLE.
  - An accept in DECAY does acc ← sat(acc_next + (trig_amp<<FRAC)) with no rise phase; tail_cnt←0, state stays DECAY, pulse_cnt+1.
  - An accept takes priority over the exit condition on the same edge.
- PULSE_GEN_PILEUP_EN undefined: trig_ready=1 only in IDLE; triggers in RISE/DECAY are ignored.

## Test plan
- Reset check: assert reset mid-DECAY → same cycle adc_data=100, pulse_active=0, pulse_cnt=0; after release trig_ready=1.
- Single pulse, amp=1000 (default parameters):
  - step=64000; acc=256000 at E0+4, so adc_data=1100 at E0+5.
  - Next samples: 1037 (acc 240000), then 978 (acc 225000).
  - Decay continues until return to 100 and pulse_active=0.
- Trigger during RISE, amp=500, macro undefined → ignored; pulse_cnt stays 1; waveform identical to the single-pulse case.
- Saturation: amp=4095 → adc_data clips at 4095 through the peak; no wrap to low values.
- Minimum pulse, amp=1:
  - acc=256 at E0+4, adc_data=101.
  - Next edge acc_next=240 has integer part 0, so state←IDLE and adc_data=100.
- Pile-up (macro defined):
  - amp=1000, then amp=500 on the first DECAY edge.
  - acc=240000+128000=368000, so adc_data=1537 (100+1437); pulse_cnt=2; single decay tail follows.

Source files
------------

// File: rtl/exp_pulse_gen.sv
// Synthetic detector pulse source: linear rise, exponential decay, baseline.
// Define PULSE_GEN_PILEUP_EN to let triggers pile onto a decaying tail.
module exp_pulse_gen #(
    parameter int DATA_W      = 12,
    parameter int FRAC        = 8,
    parameter int ACC_W       = 21,
    parameter int RISE_LOG2   = 2,
    parameter int DECAY_SHIFT = 4,
    parameter int BASELINE    = 100,
    parameter int TAIL_LEN    = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig_valid,
    input  logic [DATA_W-1:0] trig_amp,
    output logic              trig_ready,
    output logic [DATA_W-1:0] adc_data,
    output logic              pulse_active,
    output logic [15:0]       pulse_cnt
);

    localparam int IW     = ACC_W - FRAC;
    localparam int RC_W   = (RISE_LOG2 > 0) ? RISE_LOG2 : 1;
    localparam int TAIL_W = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;

    localparam logic [RC_W-1:0]   RISE_LAST = RC_W'((1 << RISE_LOG2) - 1);
    localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_LEN - 1);
    localparam logic [IW:0]       BASE_X    = (IW+1)'(BASELINE);
    localparam logic [IW:0]       DATA_MAX  = (IW+1)'((1 << DATA_W) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RISE  = 2'd1,
        DECAY = 2'd2
    } state_t;

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  step;
    logic [RC_W-1:0]   rise_cnt;
    logic [TAIL_W-1:0] tail_cnt;

    logic [ACC_W-1:0]  amp_fx;
    logic [ACC_W-1:0]  acc_dec;
    logic [IW:0]       out_sum;
    logic [DATA_W-1:0] adc_next;
    logic              accept;
    logic              tail_done;

    function automatic logic [ACC_W-1:0] sat_add(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b
    );
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

`ifdef PULSE_GEN_PILEUP_EN
    assign trig_ready = (state == IDLE) || (state == DECAY);
`else
    assign trig_ready = (state == IDLE);
`endif

    assign accept    = trig_valid && trig_ready;
    assign amp_fx    = ACC_W'({trig_amp, {FRAC{1'b0}}});
    assign acc_dec   = acc - (acc >> DECAY_SHIFT);
    assign tail_done = (acc_dec[ACC_W-1:FRAC] == '0) || (tail_cnt == TAIL_LAST);

    // Integer part plus pedestal, clipped to the ADC full scale
    assign out_sum  = {1'b0, acc[ACC_W-1:FRAC]} + BASE_X;
    assign adc_next = (out_sum > DATA_MAX) ? '1 : out_sum[DATA_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            acc          <= '0;
            step         <= '0;
            rise_cnt     <= '0;
            tail_cnt     <= '0;
            adc_data     <= DATA_W'(BASELINE);
            pulse_active <= 1'b0;
            pulse_cnt    <= '0;
        end else begin
            adc_data     <= adc_next;
            pulse_active <= (state != IDLE);
            if (accept)
                pulse_cnt <= pulse_cnt + 16'd1;
            unique case (state)
                IDLE: begin
                    acc <= '0;
                    if (accept) begin
                        step     <= amp_fx >> RISE_LOG2;
                        rise_cnt <= '0;
                        state    <= RISE;
                    end
                end
                RISE: begin
                    acc      <= sat_add(acc, step);
                    rise_cnt <= rise_cnt + RC_W'(1);
                    if (rise_cnt == RISE_LAST) begin
                        tail_cnt <= '0;
                        state    <= DECAY;
                    end
                end
                DECAY: begin
                    tail_cnt <= tail_cnt + TAIL_W'(1);
`ifdef PULSE_GEN_PILEUP_EN
                    // A new hit lands on the tail and wins over the exit test
                    if (accept) begin
                        acc      <= sat_add(acc_dec, amp_fx);
                        tail_cnt <= '0;
                    end else
`endif
                    if (tail_done) begin
                        acc   <= '0;
                        state <= IDLE;
                    end else begin
                        acc <= acc_dec;
                    end
                end
                default: begin
                    acc   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp_pulse_gen.sv
// Directed self-checking bench for exp_pulse_gen (default parameters).
module tb_exp_pulse_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trig_valid = 1'b0;
    logic [11:0] trig_amp = '0;
    logic        trig_ready;
    logic [11:0] adc_data;
    logic        pulse_active;
    logic [15:0] pulse_cnt;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    exp_pulse_gen dut (
        .clk          (clk),
        .reset        (reset),
        .trig_valid   (trig_valid),
        .trig_amp     (trig_amp),
        .trig_ready   (trig_ready),
        .adc_data     (adc_data),
        .pulse_active (pulse_active),
        .pulse_cnt    (pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Returns at the negedge just after the accept edge E0
    task automatic fire(input logic [11:0] amp);
        @(negedge clk);
        trig_valid = 1'b1;
        trig_amp   = amp;
        @(negedge clk);
        trig_valid = 1'b0;
        trig_amp   = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (pulse_active !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (pulse_active !== 1'b0) begin
            bad++;
            $display("FAIL %s_end pulse_active=%b want 0 (timeout)", tag, pulse_active);
        end
        total++;
        if (adc_data !== 12'd100) begin
            bad++;
            $display("FAIL %s_tail adc_data=%0d want 100", tag, adc_data);
        end
    endtask

    task automatic test_reset;
        #1 reset = 1'b0;
        #1;
        total++;
        if (adc_data !== 12'd100 || pulse_active !== 1'b0 || pulse_cnt !== 16'd0) begin
            bad++;
            $display("FAIL por adc=%0d act=%b cnt=%0d want 100/0/0",
                     adc_data, pulse_active, pulse_cnt);
        end
        #20 reset = 1'b1;
        @(negedge clk);
        fire(12'd1000);
        skip(8);
        total++;
        if (pulse_active !== 1'b1 || pulse_cnt !== 16'd1) begin
            bad++;
            $display("FAIL pre_rst act=%b cnt=%0d want 1/1", pulse_active, pulse_cnt);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (adc_data !== 12'd100 || pulse_active !== 1'b0 || pulse_cnt !== 16'd0) begin
            bad++;
            $display("FAIL mid_rst adc=%0d act=%b cnt=%0d want 100/0/0",
                     adc_data, pulse_active, pulse_cnt);
        end
        #1 reset = 1'b1;
        @(negedge clk);
        total++;
        if (trig_ready !== 1'b1 || adc_data !== 12'd100) begin
            bad++;
            $display("FAIL post_rst ready=%b adc=%0d want 1/100", trig_ready, adc_data);
        end
        exp_cnt = 0;
    endtask

    task automatic test_single_pulse;
        logic [11:0] exp_tab [7];
        exp_tab = '{12'd100, 12'd350, 12'd600, 12'd850, 12'd1100, 12'd1037, 12'd978};
        fire(12'd1000);
        exp_cnt++;
        total++;
        if (pulse_cnt !== 16'(exp_cnt) || trig_ready !== 1'b0 || pulse_active !== 1'b0) begin
            bad++;
            $display("FAIL single_e0 cnt=%0d ready=%b act=%b want %0d/0/0",
                     pulse_cnt, trig_ready, pulse_active, exp_cnt);
        end
        for (int k = 0; k < 7; k++) begin
            skip(1);
            total++;
            if (adc_data !== exp_tab[k] || pulse_active !== 1'b1) begin
                bad++;
                $display("FAIL single_e%0d adc=%0d act=%b want %0d/1",
                         k + 1, adc_data, pulse_active, exp_tab[k]);
            end
        end
        wait_idle("single");
    endtask

`ifndef PULSE_GEN_PILEUP_EN
    task automatic test_ignore_in_rise;
        logic [11:0] exp_tab [7];
        exp_tab = '{12'd100, 12'd350, 12'd600, 12'd850, 12'd1100, 12'd1037, 12'd978};
        fire(12'd1000);
        exp_cnt++;
        for (int k = 0; k < 7; k++) begin
            trig_valid = (k == 1 || k == 2);
            trig_amp   = 12'd500;
            if (k == 1) begin
                total++;
                if (trig_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL rise_ready ready=%b want 0", trig_ready);
                end
            end
            skip(1);
            total++;
            if (adc_data !== exp_tab[k]) begin
                bad++;
                $display("FAIL ignore_e%0d adc=%0d want %0d", k + 1, adc_data, exp_tab[k]);
            end
        end
        trig_valid = 1'b0;
        total++;
        if (pulse_cnt !== 16'(exp_cnt)) begin
            bad++;
            $display("FAIL ignore_cnt cnt=%0d want %0d", pulse_cnt, exp_cnt);
        end
        wait_idle("ignore");
    endtask
`else
    task automatic test_pileup;
        fire(12'd1000);
        exp_cnt++;
        skip(4);
        total++;
        if (adc_data !== 12'd850 || trig_ready !== 1'b1) begin
            bad++;
            $display("FAIL pile_decay adc=%0d ready=%b want 850/1", adc_data, trig_ready);
        end
        trig_valid = 1'b1;
        trig_amp   = 12'd500;
        skip(1);
        trig_valid = 1'b0;
        exp_cnt++;
        total++;
        if (adc_data !== 12'd1100 || pulse_cnt !== 16'(exp_cnt)) begin
            bad++;
            $display("FAIL pile_peak adc=%0d cnt=%0d want 1100/%0d",
                     adc_data, pulse_cnt, exp_cnt);
        end
        skip(1);
        total++;
        if (adc_data !== 12'd1537) begin
            bad++;
            $display("FAIL pile_sum adc=%0d want 1537", adc_data);
        end
        skip(1);
        total++;
        if (adc_data !== 12'd1447) begin
            bad++;
            $display("FAIL pile_tail adc=%0d want 1447", adc_data);
        end
        wait_idle("pile");
    endtask
`endif

    task automatic test_saturation;
        fire(12'd4095);
        exp_cnt++;
        skip(4);
        total++;
        if (adc_data !== 12'd3171) begin
            bad++;
            $display("FAIL sat_rise adc=%0d want 3171", adc_data);
        end
        skip(1);
        total++;
        if (adc_data !== 12'd4095) begin
            bad++;
            $display("FAIL sat_peak adc=%0d want 4095", adc_data);
        end
        skip(1);
        total++;
        if (adc_data !== 12'd3939) begin
            bad++;
            $display("FAIL sat_next adc=%0d want 3939", adc_data);
        end
        wait_idle("sat");
    endtask

    task automatic test_min_pulse;
        fire(12'd1);
        exp_cnt++;
        skip(5);
        total++;
        if (adc_data !== 12'd101 || pulse_active !== 1'b1 || trig_ready !== 1'b1) begin
            bad++;
            $display("FAIL min_peak adc=%0d act=%b ready=%b want 101/1/1",
                     adc_data, pulse_active, trig_ready);
        end
        skip(1);
        total++;
        if (adc_data !== 12'd100 || pulse_active !== 1'b0) begin
            bad++;
            $display("FAIL min_exit adc=%0d act=%b want 100/0", adc_data, pulse_active);
        end
    endtask

    task automatic test_zero_amp;
        fire(12'd0);
        exp_cnt++;
        skip(4);
        total++;
        if (trig_ready !== 1'b0 || adc_data !== 12'd100) begin
            bad++;
            $display("FAIL zero_decay ready=%b adc=%0d want 0/100", trig_ready, adc_data);
        end
        skip(1);
        total++;
        if (trig_ready !== 1'b1 || pulse_cnt !== 16'(exp_cnt)) begin
            bad++;
            $display("FAIL zero_exit ready=%b cnt=%0d want 1/%0d",
                     trig_ready, pulse_cnt, exp_cnt);
        end
        skip(1);
    endtask

    initial begin
        test_reset;
        test_single_pulse;
`ifndef PULSE_GEN_PILEUP_EN
        test_ignore_in_rise;
`else
        test_pileup;
`endif
        test_saturation;
        test_min_pulse;
        test_zero_amp;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
